up_down_counter_nb: RTL
=======================

Name: up_down_counter_nb

Overview:
- Parametrised, loadable up/down counter with a programmable terminal value.
- Successor to the fixed 4-bit up-counter in the datapath component library. Adds:
  - configurable width
  - direction control
  - a runtime upper limit
  - wrap or saturate mode
  - a registered overflow pulse
- Used by the controller/datapath designs for loop indices, timers and address generation.

Parameters:
- WIDTH, 8, counter and data width in bits (>=2).
- SATURATE, 0, boundary mode. 0 = wrap at limit; 1 = hold at boundary.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  parallel load value.
- ld  input  1  load enable.
- cnt  input  1  count enable.
- up  input  1  direction. 1 = increment, 0 = decrement.
- lim  input  WIDTH  upper bound, inclusive. Counting range is 0..lim.
- count  output  WIDTH  registered current count.
- tcount  output  1  terminal-count flag (combinational from count, lim, up).
- ovf  output  1  registered one-cycle boundary-event pulse.

Behaviour:
- All state updates on the rising edge of clk. All comparisons are unsigned.
- Priority at each edge: rst > ld > cnt > hold.
- rst = 1: count <= 0, ovf <= 0. Overrides ld and cnt in the same cycle.
- ld = 1:
  - count <= in, ovf <= 0.
  - in is not clamped; values above lim are loaded as-is.
  - Load wins over a simultaneous cnt.
- cnt = 1, ld = 0, up = 1:
  - count < lim: count <= count + 1, ovf <= 0.
  - count >= lim, SATURATE = 0: count <= 0, ovf <= 1.
  - count >= lim, SATURATE = 1: count <= lim, ovf <= 1.
- cnt = 1, ld = 0, up = 0:
  - count > lim (out of range after a load or lim change): count <= lim, ovf <= 0. Re-enters the range; not a boundary event.
  - 0 < count <= lim: count <= count - 1, ovf <= 0.
  - count == 0, SATURATE = 0: count <= lim, ovf <= 1.
  - count == 0, SATURATE = 1: count holds 0, ovf <= 1.
- cnt = 0, ld = 0: count holds, ovf <= 0.
- ovf timing:
  - Asserted for exactly one cycle, concurrent with the post-event count value.
  - Held high across consecutive cycles only if boundary events occur back-to-back (e.g. saturated and still counting).
- tcount definition:
  - up = 1: tcount = (count >= lim).
  - up = 0: tcount = (count == 0).
  - Independent of cnt; changes immediately with up or lim.
- lim = 0:
  - Range is {0}. Every counting edge is a boundary event.
  - count stays 0 and ovf = 1 while cnt is held.
- lim = 2^WIDTH - 1: full-range counter. Wrap is natural modulo 2^WIDTH.
- No intermediate arithmetic result may truncate incorrectly. Compare before increment; do not rely on the carry-out.
- lim and up may change on any cycle. They take effect at the next edge with no pipeline delay.
- Reset mid-count: count = 0 after the edge, regardless of ld/cnt. Counting resumes from 0 on the following edge if cnt = 1.
- Latency: one cycle from ld/cnt to the count update. ovf is aligned with that update.

Test Plan:
- WIDTH=4, SATURATE=0, lim=9, up=1, cnt=1 from reset, 12 cycles -> count sequence 1..9, 0, 1, 2; ovf=1 only in the cycle count=0; tcount=1 while count=9.
- WIDTH=4, SATURATE=1, lim=5, up=0:
  - ld in=2 -> count=2.
  - Then cnt for 4 cycles -> 1, 0, 0, 0; ovf=0, 0, 1, 1; tcount=1 from count=0.
- WIDTH=4, SATURATE=0, lim=6, ld in=13 then cnt with up=1 -> count=0 with ovf=1. Repeat the load with up=0 -> count=6 with ovf=0.
- Simultaneous ld=1, cnt=1, in=3 -> count=3, ovf=0. rst=1 with ld=1, in=7 -> count=0.
- WIDTH=4, SATURATE=0, lim=15, up=1, count=15, cnt -> count=0, ovf=1. Then up=0 from count 0 -> count=15, ovf=1.
- lim=0, cnt held for 3 cycles (either direction) -> count stays 0, ovf=1 each cycle, tcount=1.

Source files
------------

// File: rtl/up_down_counter_nb.sv
// up_down_counter_nb: loadable up/down counter with runtime limit, wrap/saturate mode and registered overflow pulse
module up_down_counter_nb #(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             ld,
   input  logic             cnt,
   input  logic             up,
   input  logic [WIDTH-1:0] lim,
   output logic [WIDTH-1:0] count,
   output logic             tcount,
   output logic             ovf
);
   logic             at_top;
   logic             at_bot;
   logic             above;
   logic [WIDTH-1:0] count_nxt;
   logic             ovf_nxt;
   // boundary compares happen on the current value, so increment never relies on a carry-out
   always_comb begin
      at_top = count >= lim;
      at_bot = count == '0;
      above  = count > lim;
      tcount = up ? at_top : at_bot;
   end
   // next count and boundary-event flag; load beats count, out-of-range down-count re-enters at lim silently
   always_comb begin
      count_nxt = count;
      ovf_nxt   = 1'b0;
      if (ld)
         count_nxt = in;
      else if (cnt && up) begin
         count_nxt = at_top ? (SATURATE ? lim : '0) : count + 1'b1;
         ovf_nxt   = at_top;
      end else if (cnt) begin
         count_nxt = above ? lim : at_bot ? (SATURATE ? '0 : lim) : count - 1'b1;
         ovf_nxt   = !above && at_bot;
      end
   end
   // state register with synchronous reset taking priority over load and count
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         count <= count_nxt;
         ovf   <= ovf_nxt;
      end
   end
endmodule
